// File: rtl/vga_sync_monitor.sv
// Measures VGA sync timing (line length, frame height, lit pixels), tracks lock, and captures the pixel at a probe coordinate.
// Outputs are registered one clk after the detecting pix_en cycle; there is no backpressure (pure observer).
module vga_sync_monitor #(
    parameter int H_TOTAL         = 800,
    parameter int V_TOTAL         = 525,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    input  logic        vga_R,
    input  logic        vga_G,
    input  logic        vga_B,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic [2:0]  probe_rgb,
    output logic        probe_valid,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic [18:0] lit_count,
    output logic [15:0] frame_cnt,
    output logic        locked,
    output logic        timing_err
);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
    localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);
    localparam logic [10:0] PX_MAX  = 11'h7FF;
    localparam logic [9:0]  LN_MAX  = 10'h3FF;
    localparam logic [18:0] LIT_MAX = 19'h7FFFF;

    state_t      state_q, state_d;
    logic        hs_q, hs_d, vs_q, vs_d;
    logic [2:0]  rgb_q, rgb_d;
    logic [10:0] px_q, px_d;
    logic [9:0]  ln_q, ln_d;
    logic [18:0] run_q, run_d;
    logic [2:0]  probe_rgb_q, probe_rgb_d;
    logic        probe_valid_q, probe_valid_d;
    logic [10:0] line_len_q, line_len_d;
    logic [9:0]  frame_lines_q, frame_lines_d;
    logic [18:0] lit_count_q, lit_count_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_q, err_d;

    // Sync samples are held as "active" flags so that the reset value 0 is the inactive level.
    logic        hs_in, vs_in, lit_in, hs_edge, vs_edge, sat;
    logic [11:0] px_inc;
    logic [10:0] len_meas;
    logic [9:0]  height;

    assign hs_in   = vga_h_sync ^ SYNC_ACTIVE_LOW;
    assign vs_in   = vga_v_sync ^ SYNC_ACTIVE_LOW;
    assign lit_in  = vga_R | vga_G | vga_B;
    assign hs_edge = pix_en & hs_in & ~hs_q;
    assign vs_edge = pix_en & vs_in & ~vs_q;
    assign px_inc  = {1'b0, px_q} + 12'd1;
    assign len_meas = px_inc[11] ? PX_MAX : px_inc[10:0];

    always_comb begin
        state_d       = state_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        rgb_d         = rgb_q;
        px_d          = px_q;
        ln_d          = ln_q;
        run_d         = run_q;
        probe_rgb_d   = probe_rgb_q;
        probe_valid_d = 1'b0;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        lit_count_d   = lit_count_q;
        frame_cnt_d   = frame_cnt_q;
        err_d         = err_q;
        sat           = 1'b0;
        // A coincident hsync edge closes the frame's last line too, so it counts toward the height.
        height        = (hs_edge && ln_q != LN_MAX) ? ln_q + 10'd1 : ln_q;

        if (pix_en) begin
            hs_d  = hs_in;
            vs_d  = vs_in;
            rgb_d = {vga_R, vga_G, vga_B};

            if (hs_edge) begin
                px_d       = '0;
                line_len_d = len_meas;
                if (ln_q == LN_MAX) sat = ~vs_edge;
                else                ln_d = ln_q + 10'd1;
            end else if (px_q == PX_MAX) begin
                sat = 1'b1;
            end else begin
                px_d = px_q + 11'd1;
            end

            if (lit_in && run_q != LIT_MAX) run_d = run_q + 19'd1;

            if (vs_edge) begin
                frame_lines_d = height;
                ln_d          = '0;
                lit_count_d   = run_q;
                run_d         = {18'd0, lit_in};
                frame_cnt_d   = frame_cnt_q + 16'd1;
            end

            if (state_q == LOCKED && px_q == {1'b0, probe_x} && ln_q == probe_y) begin
                probe_valid_d = 1'b1;
                probe_rgb_d   = rgb_q;
            end

            if (sat) err_d = 1'b1;

            case (state_q)
                SEARCH: if (vs_edge) state_d = CHECK;
                CHECK: begin
                    if (vs_edge)
                        state_d = (line_len_d == H_TOT && height == V_TOT) ? LOCKED : SEARCH;
                end
                LOCKED: begin
                    if ((hs_edge && len_meas != H_TOT) || (vs_edge && height != V_TOT) || sat) begin
                        state_d = SEARCH;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEARCH;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            rgb_q         <= '0;
            px_q          <= '0;
            ln_q          <= '0;
            run_q         <= '0;
            probe_rgb_q   <= '0;
            probe_valid_q <= 1'b0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            lit_count_q   <= '0;
            frame_cnt_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            rgb_q         <= rgb_d;
            px_q          <= px_d;
            ln_q          <= ln_d;
            run_q         <= run_d;
            probe_rgb_q   <= probe_rgb_d;
            probe_valid_q <= probe_valid_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            lit_count_q   <= lit_count_d;
            frame_cnt_q   <= frame_cnt_d;
            err_q         <= err_d;
        end
    end

    assign probe_rgb   = probe_rgb_q;
    assign probe_valid = probe_valid_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign lit_count   = lit_count_q;
    assign frame_cnt   = frame_cnt_q;
    assign locked      = (state_q == LOCKED);
    assign timing_err  = err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a reduced 80x24 raster (hsync 8 px, vsync 2 lines, both active-low).
module tb_vga_sync_monitor;

    localparam int H = 80;
    localparam int V = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        vga_h_sync = 1'b1;
    logic        vga_v_sync = 1'b1;
    logic        vga_R = 1'b0, vga_G = 1'b0, vga_B = 1'b0;
    logic [9:0]  probe_x = 10'd10;
    logic [9:0]  probe_y = 10'd5;
    logic [2:0]  probe_rgb;
    logic        probe_valid;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic [18:0] lit_count;
    logic [15:0] frame_cnt;
    logic        locked;
    logic        timing_err;

    int n_cmp = 0;
    int n_err = 0;
    int gap = 3;
    int mode = 0;
    int pv_cnt = 0;
    int pv0;
    logic [2:0] pv_last = 3'b000;

    vga_sync_monitor #(.H_TOTAL(H), .V_TOTAL(V), .SYNC_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
        .probe_x(probe_x), .probe_y(probe_y),
        .probe_rgb(probe_rgb), .probe_valid(probe_valid),
        .line_len(line_len), .frame_lines(frame_lines),
        .lit_count(lit_count), .frame_cnt(frame_cnt),
        .locked(locked), .timing_err(timing_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (probe_valid) begin
            pv_cnt  <= pv_cnt + 1;
            pv_last <= probe_rgb;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] colour(input int x, input int y);
        if (mode == 1 && x >= 8 && x < 72 && y >= 4 && y < 12) return 3'b010;
        if (mode == 2 && x == 10 && y == 5) return 3'b101;
        return 3'b000;
    endfunction

    // One pixel: inputs applied, sampled at the next posedge with pix_en high, then idle for gap clocks.
    task automatic pix(input logic ha, input logic va, input logic [2:0] c);
        vga_h_sync = ~ha;
        vga_v_sync = ~va;
        {vga_R, vga_G, vga_B} = c;
        pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic line(input int y, input int len);
        for (int p = 0; p < len; p++) pix(p < 8, y < 2, colour(p, y));
    endtask

    task automatic frame();
        for (int y = 0; y < V; y++) line(y, H);
    endtask

    initial begin
        #23;
        check("reset_locked", 32'(locked), 0);
        check("reset_err", 32'(timing_err), 0);
        check("reset_line_len", 32'(line_len), 0);
        check("reset_frame_lines", 32'(frame_lines), 0);
        check("reset_lit", 32'(lit_count), 0);
        check("reset_frame_cnt", 32'(frame_cnt), 0);
        check("reset_probe", 32'({probe_valid, probe_rgb}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Ideal timing, pix_en every 4th clk: partial line, then three frames.
        gap = 3;
        for (int i = 0; i < 30; i++) pix(0, 0, 3'b000);
        frame();
        check("check_state_unlocked", 32'(locked), 0);
        check("frame_cnt_1", 32'(frame_cnt), 1);
        frame();
        check("locked_after_2nd_vsync", 32'(locked), 1);
        check("line_len", 32'(line_len), H);
        check("frame_lines", 32'(frame_lines), V);
        check("no_err", 32'(timing_err), 0);
        frame();
        check("frame_cnt_3", 32'(frame_cnt), 3);
        check("still_locked", 32'(locked), 1);

        // 64x8 lit block, counted at the following vsync.
        gap = 0;
        mode = 1;
        frame();
        mode = 0;
        frame();
        check("lit_count_512", 32'(lit_count), 512);
        check("frame_cnt_5", 32'(frame_cnt), 5);

        // Single probe pixel (10,5) = R,B.
        mode = 2;
        pv0 = pv_cnt;
        frame();
        frame();
        @(negedge clk); #1;
        check("probe_pulses", 32'(pv_cnt - pv0), 2);
        check("probe_rgb", 32'(pv_last), 3'b101);
        check("lit_count_1", 32'(lit_count), 1);
        mode = 0;

        // One 81-pixel line while locked.
        for (int y = 0; y < 4; y++) line(y, (y == 3) ? H + 1 : H);
        check("locked_before_bad", 32'(locked), 1);
        pix(1, 0, 3'b000);
        check("unlock_bad_line", 32'(locked), 0);
        check("err_bad_line", 32'(timing_err), 1);
        for (int y = 4; y < V; y++) line(y, H);
        frame();
        frame();
        check("relock_after_bad", 32'(locked), 1);
        check("err_sticky", 32'(timing_err), 1);

        // Reset mid-frame while locked.
        for (int y = 0; y < 10; y++) line(y, H);
        check("locked_before_rst", 32'(locked), 1);
        rst_n = 1'b0;
        #1;
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(timing_err), 0);
        check("rst_meas", 32'({line_len, frame_lines}), 0);
        check("rst_counts", 32'({lit_count, frame_cnt}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) pix(0, 0, 3'b000);
        check("release_no_update", 32'({line_len, frame_cnt}), 0);
        frame();
        check("relock_pending", 32'(locked), 0);
        frame();
        check("relock_after_rst", 32'(locked), 1);
        check("relock_err_clear", 32'(timing_err), 0);

        // hsync missing for 2100 pixels.
        frame();
        line(0, H);
        line(1, H);
        line(2, 2101);
        check("sat_err", 32'(timing_err), 1);
        check("sat_unlock", 32'(locked), 0);
        pix(1, 0, 3'b000);
        check("sat_line_len", 32'(line_len), 2047);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
